// File: rtl/window_acc_pkg.sv
// Shared definitions for the window accumulator.
//   state_e           : ACC (collecting samples) / HOLD (presenting a result)
//   SAT_MAX / SAT_MIN : signed 8-bit saturation limits
//   EXT_* / TRN_*     : bit positions of the extended and truncated fields
//                       inside the 20-bit packed conversion word
package window_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    localparam int EXT_HI = 19;
    localparam int EXT_LO = 4;
    localparam int TRN_HI = 3;
    localparam int TRN_LO = 0;

endpackage

// File: rtl/window_accumulator_if.sv
// Handshake and result bus between the conversion stage, the window
// accumulator and its downstream consumer.
//   _i_in_valid / _i_in_data / _o_in_ready : input word handshake
//   _i_flush                               : close current window early
//   _o_out_valid / _i_out_ready            : result handshake
//   _o_sum / _o_xor / _o_count / _o_sat    : registered window result
// slave  : accumulator side
// master : environment side (upstream + downstream)
interface window_accumulator_if #(
    parameter int SUM_W = 18
);
    logic             _i_in_valid;
    logic [19:0]      _i_in_data;
    logic             _o_in_ready;
    logic             _i_flush;
    logic             _o_out_valid;
    logic             _i_out_ready;
    logic [SUM_W-1:0] _o_sum;
    logic [3:0]       _o_xor;
    logic [4:0]       _o_count;
    logic [7:0]       _o_sat;

    modport slave (
        input  _i_in_valid, _i_in_data, _i_flush, _i_out_ready,
        output _o_in_ready, _o_out_valid, _o_sum, _o_xor, _o_count, _o_sat
    );

    modport master (
        output _i_in_valid, _i_in_data, _i_flush, _i_out_ready,
        input  _o_in_ready, _o_out_valid, _o_sum, _o_xor, _o_count, _o_sat
    );
endinterface

// File: rtl/sat_narrow.sv
// Combinational narrowing of a signed SUM_W-bit value to signed 8 bits
// with saturation at -128 / +127.
//   sum_i : signed input
//   sat_o : saturated 8-bit result
module sat_narrow
    import window_acc_pkg::*;
#(
    parameter int SUM_W = 18
) (
    input  logic signed [SUM_W-1:0] sum_i,
    output logic        [7:0]       sat_o
);

    localparam logic signed [SUM_W-1:0] MAX_W = SUM_W'(SAT_MAX);
    localparam logic signed [SUM_W-1:0] MIN_W = SUM_W'(SAT_MIN);

    always_comb begin
        sat_o = sum_i[7:0];
        if (sum_i > MAX_W) begin
            sat_o = 8'h7F;
        end else if (sum_i < MIN_W) begin
            sat_o = 8'h80;
        end
    end

endmodule

// File: rtl/window_accumulator.sv
// Sums sign-extended 16-bit samples over a window of WINDOW words,
// XOR-folds the 4-bit truncated fields and presents one registered result
// per window (sum, xor, sample count, sum saturated to signed 8 bits).
//   _i_clk, _i_rst_n : clock, async active-low reset
//   bus (slave)      : input handshake, flush, result handshake and outputs
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting samples; window closes on WINDOW-th sample or flush
// HOLD  | result presented, input stalled until downstream takes it
module window_accumulator
    import window_acc_pkg::*;
#(
    parameter int WINDOW = 4,
    parameter int SUM_W  = 16 + $clog2(WINDOW)
) (
    input  logic _i_clk,
    input  logic _i_rst_n,
    window_accumulator_if.slave bus
);

    state_e           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [3:0]       x_q, x_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [3:0]       xor_q, xor_d;
    logic [4:0]       count_q, count_d;
    logic [7:0]       sat_q, sat_d;

    logic             accept;
    logic             close;
    logic [SUM_W-1:0] sample_ext;
    logic [SUM_W-1:0] acc_post;
    logic [3:0]       x_post;
    logic [4:0]       cnt_post;
    logic [7:0]       sat_post;

    assign accept     = bus._i_in_valid && (state_q == ACC);
    assign sample_ext = {{(SUM_W-16){bus._i_in_data[EXT_HI]}},
                         bus._i_in_data[EXT_HI:EXT_LO]};

    // Post-accept values: a sample accepted together with a flush is
    // included in the window being closed.
    assign acc_post = accept ? acc_q + sample_ext : acc_q;
    assign x_post   = accept ? x_q ^ bus._i_in_data[TRN_HI:TRN_LO] : x_q;
    assign cnt_post = accept ? cnt_q + 5'd1 : cnt_q;

    sat_narrow #(.SUM_W(SUM_W)) u_sat (
        .sum_i (acc_post),
        .sat_o (sat_post)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_post;
        x_d     = x_post;
        cnt_d   = cnt_post;
        sum_d   = sum_q;
        xor_d   = xor_q;
        count_d = count_q;
        sat_d   = sat_q;
        close   = 1'b0;

        case (state_q)
            ACC: begin
                close = (accept && (cnt_post == 5'(WINDOW))) ||
                        (bus._i_flush && (cnt_post != 5'd0));
                if (close) begin
                    sum_d   = acc_post;
                    xor_d   = x_post;
                    count_d = cnt_post;
                    sat_d   = sat_post;
                    acc_d   = '0;
                    x_d     = '0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus._i_out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            xor_q   <= '0;
            count_q <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            xor_q   <= xor_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    // Ready/valid are pure state decodes: no path from _i_out_ready.
    assign bus._o_in_ready  = (state_q == ACC);
    assign bus._o_out_valid = (state_q == HOLD);
    assign bus._o_sum       = sum_q;
    assign bus._o_xor       = xor_q;
    assign bus._o_count     = count_q;
    assign bus._o_sat       = sat_q;

endmodule

// File: doc/window_accumulator.md
# window_accumulator

Downstream consumer of the integer-conversion stage. It accepts the packed conversion word {extended[15:0], truncated[3:0]} over a valid/ready handshake and sign-extends each `extended` value to the accumulator width. It sums the values over a window of `WINDOW` samples, XOR-folds the `truncated` nibbles, and emits one registered result per window, including the sum saturated back to signed 8 bits.

## Interface
- `WINDOW`, default 4: samples per window; a power of two in the range 2..16.
- `SUM_W`, derived as 16 + clog2(`WINDOW`), default 18: accumulator width. The sum cannot overflow.
- `_i_clk`  in  1  clock; all state updates on the rising edge.
- `_i_rst_n`  in  1  reset; asynchronous, active-low.
- `_i_in_valid`  in  1  upstream word valid.
- `_i_in_data`  in  20  {extended[15:0] signed, truncated[3:0]} from the conversion stage.
- `_o_in_ready`  out  1  block can accept a word.
- `_i_flush`  in  1  close the current window early.
- `_o_out_valid`  out  1  result valid.
- `_i_out_ready`  in  1  downstream accepts the result.
- `_o_sum`  out  `SUM_W`  signed sum of the sign-extended `extended` fields.
- `_o_xor`  out  4  XOR of the `truncated` fields in the window.
- `_o_count`  out  5  number of samples in the window (1..`WINDOW`).
- `_o_sat`  out  8  `_o_sum` saturated to the signed range -128..127.

## Operation
- Two states.
  - ACC: `_o_in_ready`=1, `_o_out_valid`=0.
  - HOLD: `_o_in_ready`=0, `_o_out_valid`=1.
- Accept means `_i_in_valid` & `_o_in_ready`. On accept:
  - acc += sext(`_i_in_data[19:4]`) to `SUM_W`.
  - x ^= `_i_in_data[3:0]`.
  - cnt += 1.
- Window close happens in ACC when either condition holds:
  - an accept brings cnt to `WINDOW`;
  - `_i_flush`=1 and the post-accept cnt is at least 1.
- Accept and flush in the same cycle: the accepted sample is included, then the window closes.
- On close:
  - the output registers load the post-accept acc, x, cnt and the saturated value;
  - the state goes to HOLD;
  - the accumulators clear to 0.
- Saturation rule:
  - sum > 127 gives 0x7F;
  - sum < -128 gives 0x80;
  - otherwise sum[7:0].
- Flush with cnt=0 and no accept is ignored.
- Flush in HOLD is ignored.
- HOLD with `_i_out_ready`=1 returns to ACC on the next edge.
- HOLD with `_i_out_ready`=0: all outputs stay stable; `_i_in_valid` is ignored.
- `_o_in_ready` is a decode of the state register only. It has no combinational path from `_i_out_ready`.

## Timing
- Reset values, asserted asynchronously:
  - state ACC;
  - acc, x, cnt = 0;
  - `_o_sum`, `_o_xor`, `_o_count`, `_o_sat`, `_o_out_valid` = 0;
  - `_o_in_ready`=1 once reset is released.
- Reset mid-window or mid-HOLD discards all partial data and any pending result.
- Latency: `_o_out_valid` rises one cycle after the closing accept or flush edge.
- Handshake bubble: the result is consumed in the cycle `_o_out_valid` & `_i_out_ready`. `_o_in_ready` rises on the following edge, giving one bubble.
- Maximum throughput: one window per `WINDOW`+1 cycles.

## Structure
- Package `window_acc_pkg` holds:
  - the state enum {ACC, HOLD};
  - constants `SAT_MAX`=127 and `SAT_MIN`=-128;
  - field positions `EXT_HI`=19, `EXT_LO`=4, `TRN_HI`=3, `TRN_LO`=0.
- One sub-module, `sat_narrow`: combinational, `SUM_W`-bit signed in, 8-bit saturated out.

## Test plan
- Reset, then 4 words with extended=1 and truncated=1:
  - cycle after the 4th accept: out_valid=1, sum=4, xor=0, count=4, sat=0x04;
  - in_ready=0 while in HOLD.
- 4 words with extended=0xFFFF and truncated=0xF: sum=18'h3FFFC (-4), xor=0, count=4, sat=0xFC.
- 4 words with extended=0xFF8A and truncated=0xA: sum=-472, sat=0x80, xor=0.
- 4 words with extended=0x7FFF: sum=18'h1FFFC (131068), sat=0x7F.
  - Then hold out_ready=0 for 3 cycles while driving in_valid=1: outputs stay stable, no accept occurs.
  - Then out_ready=1: in_ready rises on the next edge.
- Flush scenarios:
  - accept 5, then -3, then flush alone: count=2, sum=2, sat=0x02;
  - flush with count=0: no out_valid;
  - accept and flush in the same cycle with 1 prior sample: count=2.
- Reset asserted after 3 accepts: no output.
  - The next 4 words (extended=2) give sum=8, count=4.
